// File: rtl/load_store_unit_pkg.sv
// Shared opcode/funct3 constants and the load/store FSM state type.
package rv_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;
endpackage

// File: rtl/load_store_unit_store_align.sv
// Access decode: funct3 legality, address alignment and store byte-lane formatting.
module store_align
    import rv_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_aligned,
    output logic        o_legal
);
    always_comb begin
        o_legal = 1'b0;
        case (i_funct3)
            F3_B, F3_H, F3_W: o_legal = 1'b1;
            F3_BU, F3_HU:     o_legal = !i_is_store;
            default:          o_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_aligned = 1'b1;
        case (i_funct3[1:0])
            2'b01:   o_aligned = !i_addr_lo[0];
            2'b10:   o_aligned = (i_addr_lo == 2'b00);
            default: o_aligned = 1'b1;
        endcase
    end

    // Loads drive no lanes and no data so the request fields stay deterministic.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        if (i_is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    o_be    = 4'b0011 << i_addr_lo;
                    o_wdata = {2{i_store_data[15:0]}};
                end
                2'b10: begin
                    o_be    = 4'b1111;
                    o_wdata = i_store_data;
                end
                default: begin
                    o_be    = 4'b0000;
                    o_wdata = 32'h0;
                end
            endcase
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: one outstanding access, pipeline stalled until DONE.
module load_store_unit
    import rv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_stall,
    output logic              o_mem_fault,
    output logic [31:0]       o_mem_res,
    output logic              o_dmem_req_valid,
    input  logic              i_dmem_req_ready,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_be,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_resp_valid,
    input  logic [31:0]       i_dmem_rdata,
    output logic [1:0]        o_dbg_state
);
    lsu_state_t r_state;
    logic       r_is_load;
    logic [1:0] r_addr_lo;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_aligned;
    logic        w_legal;
    logic        w_accept;

    assign w_is_load  = (i_opcode == OP_LOAD);
    assign w_is_store = (i_opcode == OP_STORE);
    assign w_mem_op   = w_is_load || w_is_store;

    store_align u_store_align (
        .i_is_store   (w_is_store),
        .i_funct3     (i_funct3),
        .i_addr_lo    (i_addr[1:0]),
        .i_store_data (i_store_data),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_aligned    (w_aligned),
        .o_legal      (w_legal)
    );

    assign w_accept    = (r_state == IDLE) && i_valid && w_mem_op && w_legal && w_aligned;
    assign o_stall     = i_rst_n && (w_accept || (r_state == REQ) || (r_state == WAIT));
    assign o_mem_fault = i_rst_n && (r_state == IDLE) && i_valid && w_mem_op && !(w_legal && w_aligned);
    assign o_dbg_state = r_state;

    // Request handshake: dmem_req_valid rises on accept, request fields stay frozen
    // until the cycle where valid && ready are both high, then valid drops.
    // Responses are only honoured in WAIT, i.e. after the handshake has completed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= IDLE;
            r_is_load        <= 1'b0;
            r_addr_lo        <= 2'b00;
            o_mem_res        <= 32'h0;
            o_dmem_req_valid <= 1'b0;
            o_dmem_we        <= 1'b0;
            o_dmem_addr      <= '0;
            o_dmem_be        <= 4'b0000;
            o_dmem_wdata     <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state          <= REQ;
                        r_is_load        <= w_is_load;
                        r_addr_lo        <= i_addr[1:0];
                        o_dmem_req_valid <= 1'b1;
                        o_dmem_we        <= w_is_store;
                        o_dmem_addr      <= {i_addr[ADDR_W-1:2], 2'b00};
                        o_dmem_be        <= w_be;
                        o_dmem_wdata     <= w_wdata;
                    end
                end
                REQ: begin
                    if (i_dmem_req_ready) begin
                        o_dmem_req_valid <= 1'b0;
                        r_state          <= r_is_load ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (i_dmem_resp_valid) begin
                        o_mem_res <= i_dmem_rdata >> {r_addr_lo, 3'b000};
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with request/result scoreboard queues.
module tb_load_store_unit;
  import rv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        mem_fault;
  logic [31:0] mem_res;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [31:0] dmem_addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] last_res = 32'h0;
  logic [68:0] exp_req_q[$];
  logic [31:0] exp_res_q[$];

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_valid           (valid),
    .i_opcode          (opcode),
    .i_funct3          (funct3),
    .i_addr            (addr),
    .i_store_data      (store_data),
    .o_stall           (stall),
    .o_mem_fault       (mem_fault),
    .o_mem_res         (mem_res),
    .o_dmem_req_valid  (req_valid),
    .i_dmem_req_ready  (req_ready),
    .o_dmem_we         (we),
    .o_dmem_addr       (dmem_addr),
    .o_dmem_be         (be),
    .o_dmem_wdata      (wdata),
    .i_dmem_resp_valid (resp_valid),
    .i_dmem_rdata      (rdata),
    .o_dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd);
    valid = 1'b1;
    opcode = op;
    funct3 = f3;
    addr = a;
    store_data = sd;
  endtask

  // Runs one accepted access; called just after a clock edge with inputs driven.
  task automatic run_access(input int ready_lag, input int resp_lag, input logic [31:0] rd,
                            input bit spur_resp, input int exp_stalls);
    int stalls = 0;
    int waited = 0;
    int hs = -1;
    bit done = 1'b0;
    logic [68:0] obs;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (stall) stalls++;
      req_ready = 1'b0;
      resp_valid = 1'b0;
      rdata = $urandom;
      if (req_valid) begin
        obs = {we, dmem_addr, be, wdata};
        if (exp_req_q.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else if (waited >= ready_lag) begin
          req_ready = 1'b1;
          check("req_fields", obs, exp_req_q.pop_front());
          hs = c;
        end else begin
          check("req_hold", obs, exp_req_q[0]);
          waited++;
          if (spur_resp) resp_valid = 1'b1;
        end
      end
      if (resp_lag > 0 && hs >= 0 && c == hs + resp_lag) begin
        resp_valid = 1'b1;
        rdata = rd;
      end
      if (dbg_state == DONE) begin
        if (exp_res_q.size() > 0) begin
          last_res = exp_res_q.pop_front();
          check("mem_res", mem_res, last_res);
        end else begin
          check("mem_res_hold", mem_res, last_res);
        end
        check("stall_cycles", stalls, exp_stalls);
        check("done_stall", stall, 0);
        done = 1'b1;
      end
      tick();
      if (done) begin
        valid = 1'b0;
        req_ready = 1'b0;
        resp_valid = 1'b0;
      end
    end
    if (!done) check("access_timeout", 0, 1);
  endtask

  task automatic fault_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] a);
    drive_op(op, f3, a, $urandom);
    #1;
    check({tag, "_fault"}, mem_fault, 1);
    check({tag, "_stall"}, stall, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_no_req"}, req_valid, 0);
      check({tag, "_state"}, dbg_state, IDLE);
      check({tag, "_res_hold"}, mem_res, last_res);
    end
    valid = 1'b0;
    #1;
    check({tag, "_fault_clear"}, mem_fault, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    rdata = 32'h0;
    drive_op(OP_LOAD, F3_W, 32'h0000_0100, 32'h0);
    #12;
    check("rst_state", dbg_state, IDLE);
    check("rst_stall", stall, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_mem_res", mem_res, 0);
    check("rst_req", {req_valid, we, dmem_addr, be, wdata}, 0);
    valid = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();

    // SB, upper lane
    drive_op(OP_STORE, F3_B, 32'h0000_1003, 32'h0000_00A5);
    exp_req_q.push_back({1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5});
    run_access(0, 0, 32'h0, 1'b0, 2);

    // LH, upper half, response 3 cycles after handshake
    drive_op(OP_LOAD, F3_H, 32'h0000_2002, $urandom);
    exp_req_q.push_back({1'b0, 32'h0000_2000, 4'b0000, 32'h0});
    exp_res_q.push_back(32'h0000_BEEF);
    run_access(0, 3, 32'hBEEF_1234, 1'b0, 5);

    fault_case("lw_misalign", OP_LOAD, F3_W, 32'h0000_3001);
    fault_case("ld_f3_011", OP_LOAD, 3'b011, 32'h0000_3000);
    fault_case("st_f3_100", OP_STORE, 3'b100, 32'h0000_3000);
    fault_case("sh_misalign", OP_STORE, F3_H, 32'h0000_3003);

    // SW with ready low for 4 cycles
    drive_op(OP_STORE, F3_W, 32'h0000_4008, 32'hCAFE_F00D);
    exp_req_q.push_back({1'b1, 32'h0000_4008, 4'b1111, 32'hCAFE_F00D});
    run_access(4, 0, 32'h0, 1'b0, 6);

    // LB with a spurious response while still in REQ
    drive_op(OP_LOAD, F3_B, 32'h0000_4001, $urandom);
    exp_req_q.push_back({1'b0, 32'h0000_4000, 4'b0000, 32'h0});
    exp_res_q.push_back(32'h0011_2233);
    run_access(2, 1, 32'h1122_3344, 1'b1, 5);

    // SH upper half
    drive_op(OP_STORE, F3_H, 32'h0000_5002, 32'h1234_ABCD);
    exp_req_q.push_back({1'b1, 32'h0000_5000, 4'b1100, 32'hABCD_ABCD});
    run_access(0, 0, 32'h0, 1'b0, 2);

    // LBU top byte
    drive_op(OP_LOAD, F3_BU, 32'h0000_5003, $urandom);
    exp_req_q.push_back({1'b0, 32'h0000_5000, 4'b0000, 32'h0});
    exp_res_q.push_back(32'h0000_0089);
    run_access(0, 2, 32'h89AB_CDEF, 1'b0, 4);

    // Non-memory opcode
    drive_op(7'b0110011, F3_W, 32'h0000_6000, $urandom);
    #1;
    check("alu_stall", stall, 0);
    check("alu_fault", mem_fault, 0);
    tick();
    check("alu_no_req", req_valid, 0);
    check("alu_res_hold", mem_res, last_res);
    valid = 1'b0;
    tick();

    // LW interrupted by reset while in WAIT
    drive_op(OP_LOAD, F3_W, 32'h0000_7000, $urandom);
    tick();
    check("mid_req_state", dbg_state, REQ);
    check("mid_req", {req_valid, we, dmem_addr}, {1'b1, 1'b0, 32'h0000_7000});
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("mid_wait_state", dbg_state, WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_res", mem_res, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_req", req_valid, 0);
    valid = 1'b0;
    #2;
    rst_n = 1'b1;
    resp_valid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    check("late_resp_state", dbg_state, IDLE);
    check("late_resp_res", mem_res, 0);
    last_res = 32'h0;

    // Next access after reset proceeds normally
    drive_op(OP_LOAD, F3_W, 32'h0000_6000, $urandom);
    exp_req_q.push_back({1'b0, 32'h0000_6000, 4'b0000, 32'h0});
    exp_res_q.push_back(32'h0F0F_0F0F);
    run_access(0, 1, 32'h0F0F_0F0F, 1'b0, 3);

    check("req_q_drained", exp_req_q.size(), 0);
    check("res_q_drained", exp_res_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
